// File: rtl/sbox_layer_ctrl_if.sv
// Block handshake bundle for the S-box layer sequencer.
// Carries in_inv only when SBOX_INV_EN is defined.
interface sbox_layer_ctrl_if #(
  parameter int BLOCK_W = 64
);
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
`ifdef SBOX_INV_EN
  logic               in_inv;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
`ifdef SBOX_INV_EN
    output in_inv,
`endif
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
`ifdef SBOX_INV_EN
    input  in_inv,
`endif
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );
endinterface

// File: rtl/sbox_layer_ctrl.sv
// PRESENT S-box layer, LANES nibbles per cycle over one block.
// SBOX_INV_EN adds the in_inv port and the inverse table.
module sbox_layer_ctrl #(
  parameter int BLOCK_W = 64,
  parameter int LANES   = 4
) (
  input  logic clk,
  input  logic rst_n,
  sbox_layer_ctrl_if.slave io,
  output logic busy
);

  localparam int NIB = BLOCK_W / 4;
  localparam int G   = NIB / LANES;
  localparam int GW  = (G > 1) ? $clog2(G) : 1;
  localparam logic [GW-1:0] GLAST = GW'(G - 1);

  // Table entry x lives at bits [4x+3:4x]
  localparam logic [63:0] FWD = 64'h21748FE3DA09B65C;
`ifdef SBOX_INV_EN
  localparam logic [63:0] INV = 64'hA970364BD21C8FE5;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [BLOCK_W-1:0] st_q;
  logic [BLOCK_W-1:0] st_d;
  logic [BLOCK_W-1:0] sub_st;
  logic [GW-1:0]      grp_q;
  logic [GW-1:0]      grp_d;
`ifdef SBOX_INV_EN
  logic               inv_q;
  logic               inv_d;
`endif

  function automatic logic [3:0] lut(
    input logic [3:0] x
`ifdef SBOX_INV_EN
    , input logic inv
`endif
  );
    logic [5:0] idx;
    idx = {x, 2'b00};
`ifdef SBOX_INV_EN
    if (inv) return INV[idx +: 4];
`endif
    return FWD[idx +: 4];
  endfunction

  always_comb begin
    sub_st = st_q;
    for (int k = 0; k < NIB; k++) begin
      if (k / LANES == int'(grp_q)) begin
`ifdef SBOX_INV_EN
        sub_st[4*k +: 4] = lut(st_q[4*k +: 4], inv_q);
`else
        sub_st[4*k +: 4] = lut(st_q[4*k +: 4]);
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    grp_d   = grp_q;
`ifdef SBOX_INV_EN
    inv_d   = inv_q;
`endif
    unique case (1'b1)
      (state_q == IDLE): begin
        if (io.in_valid) begin
          state_d = SUB;
          st_d    = io.in_data;
          grp_d   = '0;
`ifdef SBOX_INV_EN
          inv_d   = io.in_inv;
`endif
        end
      end
      (state_q == SUB): begin
        st_d = sub_st;
        if (grp_q == GLAST) begin
          state_d = DONE;
          grp_d   = '0;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      (state_q == DONE): begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      grp_q   <= '0;
`ifdef SBOX_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      grp_q   <= grp_d;
`ifdef SBOX_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.out_data  = st_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_layer_ctrl.sv
// Scoreboard bench for sbox_layer_ctrl against a table model.
// Define SBOX_INV_EN to exercise the inverse path.
module tb_sbox_layer_ctrl #(
  parameter int BLOCK_W = 64,
  parameter int LANES   = 4
);

  localparam int NIB = BLOCK_W / 4;
  localparam int G   = NIB / LANES;

  typedef logic [BLOCK_W-1:0] blk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic rand_rdy = 1'b0;

  blk_t exp_q[$];
  int   lat_q[$];

  sbox_layer_ctrl_if #(.BLOCK_W(BLOCK_W)) io();

  sbox_layer_ctrl #(
    .BLOCK_W(BLOCK_W),
    .LANES  (LANES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input blk_t act, input blk_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    fails++;
    $display("FAIL %s", nm);
  endtask

  function automatic blk_t model(input blk_t x, input logic inv);
    int f[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    int r[16] = '{5, 14, 15, 8, 12, 1, 2, 13, 11, 4, 6, 3, 0, 7, 9, 10};
    blk_t y;
    int   v;
    for (int k = 0; k < NIB; k++) begin
      v = int'(x[4*k +: 4]);
      y[4*k +: 4] = inv ? 4'(r[v]) : 4'(f[v]);
    end
    return y;
  endfunction

  function automatic blk_t rep(input logic [63:0] p);
    blk_t y;
    for (int k = 0; k < NIB; k++) y[4*k +: 4] = p[4*(k % 16) +: 4];
    return y;
  endfunction

  function automatic blk_t rnd();
    blk_t y;
    for (int k = 0; k < NIB; k++) y[4*k +: 4] = 4'($urandom);
    return y;
  endfunction

  // Scoreboard monitor: latency on rise, hold while stalled, data on handshake
  logic prev_v = 1'b0;
  logic hs = 1'b0;
  blk_t held;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
      hs = 1'b0;
    end else begin
      if (hs) begin
        chk("post_hs in_ready", blk_t'(io.in_ready), blk_t'(1));
        chk("post_hs out_valid", blk_t'(io.out_valid), blk_t'(0));
        hs = 1'b0;
      end
      if (io.out_valid && !prev_v) begin
        if (lat_q.size() == 0) flag("unexpected out_valid");
        else chk("latency", blk_t'(cyc), blk_t'(lat_q.pop_front()));
      end
      if (io.out_valid && prev_v) chk("hold out_data", io.out_data, held);
      held = io.out_data;
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) flag("unexpected output");
        else chk("out_data", io.out_data, exp_q.pop_front());
        hs = 1'b1;
      end
      prev_v = io.out_valid && !io.out_ready;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) io.out_ready = 1'($urandom);
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input blk_t d, input logic inv, input blk_t exp,
                      output int t0);
    logic rdy;
    int   n;
    n = 0;
    t0 = -1;
    io.in_valid = 1'b1;
    io.in_data = d;
`ifdef SBOX_INV_EN
    io.in_inv = inv;
`endif
    while (t0 < 0) begin
      @(negedge clk);
      rdy = io.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        t0 = cyc;
        exp_q.push_back(exp);
        lat_q.push_back(t0 + G);
      end else if (++n > 300) begin
        flag("accept timeout");
        break;
      end
    end
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 || io.out_valid) begin
      @(posedge clk);
      #1;
      if (++n > 400) begin
        flag("drain timeout");
        exp_q.delete();
        lat_q.delete();
        break;
      end
    end
  endtask

  initial begin
    int   t0;
    int   tp;
    blk_t d;
    blk_t y;
    logic inv;

    io.in_valid = 1'b0;
    io.in_data = '0;
`ifdef SBOX_INV_EN
    io.in_inv = 1'b0;
`endif
    io.out_ready = 1'b1;
    #1;
    chk("rst in_ready", blk_t'(io.in_ready), blk_t'(1));
    chk("rst out_valid", blk_t'(io.out_valid), blk_t'(0));
    chk("rst busy", blk_t'(busy), blk_t'(0));
    chk("rst out_data", io.out_data, blk_t'(0));
    #21;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(rep(64'h0123456789ABCDEF), 1'b0, rep(64'hC56B90AD3EF84712), t0);
    drain();
    send('0, 1'b0, rep(64'hCCCCCCCCCCCCCCCC), t0);
    drain();

    // Stall downstream for 10 cycles with a competing input offered
    io.out_ready = 1'b0;
    d = rnd();
    send(d, 1'b0, model(d, 1'b0), t0);
    for (int i = 0; i < G + 5 && !io.out_valid; i++) @(negedge clk);
    if (!io.out_valid) flag("stall out_valid timeout");
    io.in_valid = 1'b1;
    io.in_data = ~d;
    repeat (10) begin
      @(negedge clk);
      chk("stall in_ready", blk_t'(io.in_ready), blk_t'(0));
      chk("stall out_valid", blk_t'(io.out_valid), blk_t'(1));
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    drain();

    // Reset in the second SUB cycle discards the block
    send(rnd(), 1'b0, '0, t0);
    if (G > 1) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", blk_t'(io.in_ready), blk_t'(1));
    chk("midrst out_valid", blk_t'(io.out_valid), blk_t'(0));
    chk("midrst busy", blk_t'(busy), blk_t'(0));
    chk("midrst out_data", io.out_data, blk_t'(0));
    exp_q.delete();
    lat_q.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send('1, 1'b0, rep(64'h2222222222222222), t0);
    drain();

    // Back-to-back with out_ready high: one block per G+2 cycles
    tp = -1;
    for (int i = 0; i < 4; i++) begin
      d = rnd();
      send(d, 1'b0, model(d, 1'b0), t0);
      if (tp >= 0) chk("throughput", blk_t'(t0 - tp), blk_t'(G + 2));
      tp = t0;
    end
    drain();

`ifdef SBOX_INV_EN
    send(rep(64'hC56B90AD3EF84712), 1'b1, rep(64'h0123456789ABCDEF), t0);
    drain();
    for (int i = 0; i < 6; i++) begin
      d = rnd();
      y = model(d, 1'b0);
      send(d, 1'b0, y, t0);
      send(y, 1'b1, d, t0);
    end
    drain();
`endif

    // Random blocks under random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      d = rnd();
`ifdef SBOX_INV_EN
      inv = 1'($urandom);
`else
      inv = 1'b0;
`endif
      y = model(d, inv);
      send(d, inv, y, t0);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    io.out_ready = 1'b1;
    drain();
    chk("scoreboard empty", blk_t'(exp_q.size()), blk_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/sbox_layer_ctrl.md
# sbox_layer_ctrl

Sequences the 4-bit PRESENT substitution layer across a full cipher state block. It time-shares a small number of S-box lanes over the nibbles of the block, `LANES` nibbles per cycle. It sits between the round-key XOR stage and the permutation layer of the round datapath. Blocks are exchanged over valid/ready handshakes on both sides, and one block is processed at a time.

## Interface
- `BLOCK_W`, default 64: state width in bits. Must be a multiple of 4.
- `LANES`, default 4: number of S-box lanes. Must divide `BLOCK_W/4`.
- `clk` in, 1: sole clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `in_valid` in, 1: `in_data` is offered.
- `in_ready` out, 1: block can accept input.
- `in_data` in, `BLOCK_W`: state to substitute.
- `in_inv` in, 1: select inverse S-box. Present only when `SBOX_INV_EN` is defined.
- `out_valid` out, 1: `out_data` holds a substituted block.
- `out_ready` in, 1: downstream accepts `out_data`.
- `out_data` out, `BLOCK_W`: substituted state.
- `busy` out, 1: high in SUB and DONE.

## Operation
- Forward table, indexed 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Nibble k is `bits[4k+3:4k]`. G = `BLOCK_W/(4*LANES)` is the number of groups (4 at the defaults).
- Internal registers:
  - `st_q`, `BLOCK_W` bits: working state.
  - `grp_q`, ceil(log2 G) bits, minimum 1: current group.
  - `inv_q`: latched `in_inv`.
  - FSM state.
- FSM states are IDLE, SUB and DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: `st_q <= in_data`, `grp_q <= 0`, latch `inv_q`, go to SUB.
- SUB:
  - Each cycle, replace nibbles `grp_q*LANES` through `grp_q*LANES+LANES-1` of `st_q` with their table values. All other nibbles hold.
  - `grp_q` increments each SUB cycle.
  - In the SUB cycle where `grp_q == G-1`, go to DONE and clear `grp_q` to 0. `grp_q` does not wrap inside SUB.
- DONE:
  - `out_valid` = 1 and `out_data` = `st_q`. Both are stable until the handshake.
  - On `out_ready`, go to IDLE.
- `in_ready` is 0 in SUB and DONE. `in_valid` in those states is ignored, and the upstream holds its data.
- `out_data` equals `st_q` in every state. It carries meaning only while `out_valid` = 1.

## Timing
- Reset (`rst_n` low, asynchronous) forces:
  - FSM to IDLE, `st_q` = 0, `grp_q` = 0, `inv_q` = 0.
  - `in_ready` = 1, `out_valid` = 0, `busy` = 0, `out_data` = 0.
- Reset asserted mid-SUB or in DONE discards the block immediately, with no partial output.
- Deassertion of reset is synchronized externally. The first accept can occur at the first clock edge after deassertion.
- Input handshake at edge t0 gives SUB during cycles t0..t0+G-1. `out_valid` rises at edge t0+G, which is 4 cycles at the defaults.
- Output handshake at edge t1 gives `in_ready` = 1 from t1. The next input handshake can occur at edge t1+1.
- Throughput is one block per G+2 cycles when `out_ready` is held high.
- `out_ready` high outside DONE has no effect.
- All outputs are registered or decoded from FSM state only. There is no combinational path from inputs to outputs.

## Configuration
- `SBOX_INV_EN` defined:
  - Adds the `in_inv` port and the inverse table, indexed 0..F: 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
  - Each lane uses the inverse table when `inv_q` = 1.
- `SBOX_INV_EN` undefined:
  - No `in_inv` port.
  - Forward table only; `inv_q` is not implemented.

## Test plan
- After reset: `in_ready` = 1, `out_valid` = 0, `busy` = 0, `out_data` = 0.
- `in_data` = 0x0123456789ABCDEF at the defaults gives `out_data` = 0xC56B90AD3EF84712 with `out_valid` rising exactly 4 edges after the accept.
- `in_data` = 0 gives 0xCCCCCCCCCCCCCCCC.
- `out_ready` held low for 10 cycles:
  - `out_valid` and `out_data` hold.
  - `in_ready` = 0 throughout, and a new `in_valid` is ignored.
  - Release gives one output handshake, then IDLE.
- `rst_n` pulsed low during the second SUB cycle: all outputs are at reset values immediately. The next block, 0xFFFFFFFFFFFFFFFF, gives 0x2222222222222222.
- With `SBOX_INV_EN` and `in_inv` = 1, `in_data` = 0xC56B90AD3EF84712 gives 0x0123456789ABCDEF.
- Round-trip of random blocks through forward then inverse returns the original block.
- Repeat with `LANES` = 1 (G = 16) and `LANES` = 16 (G = 1).
